execute_stage: RTL and testbench

- Execute stage of the 5-stage ARM pipeline. It sits directly upstream of the memory stage and drives that stage's ALUOutM, WriteDataM, WA3M and control inputs.
- Contains the ALU, the NZCV flags register, the condition-check unit, and the EX/MEM pipeline register with stall and flush.
- A condition-failed instruction reaches the memory stage with all side-effect controls cleared.

---
 rtl/execute_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// Execute stage of the 5-stage ARM pipeline: ALU, NZCV flags register,
// condition-check unit and the EX/MEM pipeline register feeding the memory
// stage. An instruction whose condition fails still travels to M with its
// ALU result and data, but its side-effect controls (RegWrite, MemWrite,
// PCSrc) and its flag updates are suppressed.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high; beats flushE and stallE
//   stallE       hold EX/MEM register and flags
//   flushE       load a bubble into EX/MEM; squash the instruction in E
//   SrcAE/SrcBE  ALU operands
//   WriteDataE   store data
//   WA3E         destination register index (zero-extended to WIDTH)
//   ALUControlE  00 ADD, 01 SUB, 10 AND, 11 ORR
//   FlagWriteE   bit1 enables NZ update, bit0 enables CV update
//   CondE        ARM condition field
//   RegWriteE, MemWriteE, MemToRegE, PCSrcE, PlusOneE  decoder controls
//   ALUOutM, WriteDataM, WA3M                          registered data
//   RegWriteM, MemWriteM, MemToRegM, PCSrcM, PlusOneM  registered controls
//   FlagsOut     current flags register {N,Z,C,V}
//   CondExE      combinational condition pass for the instruction in E
// -----------------------------------------------------------------------------
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stallE,
    input  logic             flushE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [WIDTH-1:0] WA3E,
    input  logic [1:0]       ALUControlE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             MemToRegE,
    input  logic             PCSrcE,
    input  logic             PlusOneE,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] WA3M,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemToRegM,
    output logic             PCSrcM,
    output logic             PlusOneM,
    output logic [3:0]       FlagsOut,
    output logic             CondExE
);

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Everything the memory stage sees from this stage, registered together.
    typedef struct packed {
        logic [WIDTH-1:0] alu_out;
        logic [WIDTH-1:0] write_data;
        logic [WIDTH-1:0] wa3;
        logic             reg_write;
        logic             mem_write;
        logic             mem_to_reg;
        logic             pc_src;
        logic             plus_one;
    } exmem_t;

    alu_op_e alu_op;
    cond_e   cond;

    assign alu_op = alu_op_e'(ALUControlE);
    assign cond   = cond_e'(CondE);

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic             is_sub;
    logic [WIDTH-1:0] b_operand;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_result;
    logic             alu_n;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;

    // NOTE: every signal assigned in an always_comb gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        is_sub     = (alu_op == ALU_SUB);
        // SUB is A + ~B + 1, so one adder serves both arithmetic ops and the
        // carry out directly means "no borrow".
        b_operand  = is_sub ? ~SrcBE : SrcBE;
        sum_ext    = {1'b0, SrcAE} + {1'b0, b_operand} + {{WIDTH{1'b0}}, is_sub};
        alu_result = sum_ext[WIDTH-1:0];
        alu_c      = 1'b0;
        alu_v      = 1'b0;

        case (alu_op)
            ALU_ADD, ALU_SUB: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_c      = sum_ext[WIDTH];
                // Overflow: operands agree in sign but the result does not.
                alu_v      = (SrcAE[WIDTH-1] == b_operand[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != SrcAE[WIDTH-1]);
            end
            ALU_AND: alu_result = SrcAE & SrcBE;
            ALU_ORR: alu_result = SrcAE | SrcBE;
            default: alu_result = sum_ext[WIDTH-1:0];
        endcase

        alu_n = alu_result[WIDTH-1];
        alu_z = (alu_result == '0);
    end

    // ------------------------------------------------------------------
    // Flags register and condition check
    // ------------------------------------------------------------------
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign FlagsOut = {flag_n, flag_z, flag_c, flag_v};

    // The check reads the registered flags, i.e. the state left by the
    // previous instruction; a dependent conditional directly behind a
    // flag-setter sees the value written on the edge between them.
    always_comb begin
        CondExE = 1'b0;
        case (cond)
            COND_EQ: CondExE = flag_z;
            COND_NE: CondExE = ~flag_z;
            COND_CS: CondExE = flag_c;
            COND_CC: CondExE = ~flag_c;
            COND_MI: CondExE = flag_n;
            COND_PL: CondExE = ~flag_n;
            COND_VS: CondExE = flag_v;
            COND_VC: CondExE = ~flag_v;
            COND_HI: CondExE = flag_c & ~flag_z;
            COND_LS: CondExE = ~flag_c | flag_z;
            COND_GE: CondExE = (flag_n == flag_v);
            COND_LT: CondExE = (flag_n != flag_v);
            COND_GT: CondExE = ~flag_z & (flag_n == flag_v);
            COND_LE: CondExE = flag_z | (flag_n != flag_v);
            COND_AL: CondExE = 1'b1;
            COND_NV: CondExE = 1'b0;
            default: CondExE = 1'b0;
        endcase
    end

    // Side effects only survive a passing condition.
    logic [1:0] flag_write_g;

    assign flag_write_g = FlagWriteE & {2{CondExE}};

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of the order of statements.
    always_ff @(posedge clock) begin
        if (reset) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (!flushE && !stallE) begin
            if (flag_write_g[1]) begin
                flag_n <= alu_n;
                flag_z <= alu_z;
            end
            if (flag_write_g[0]) begin
                flag_c <= alu_c;
                flag_v <= alu_v;
            end
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    exmem_t exmem_d;
    exmem_t exmem_q;

    always_comb begin
        exmem_d            = '0;
        exmem_d.alu_out    = alu_result;
        exmem_d.write_data = WriteDataE;
        exmem_d.wa3        = WA3E;
        exmem_d.reg_write  = RegWriteE & CondExE;
        exmem_d.mem_write  = MemWriteE & CondExE;
        exmem_d.pc_src     = PCSrcE & CondExE;
        exmem_d.mem_to_reg = MemToRegE;
        exmem_d.plus_one   = PlusOneE;
    end

    // Priority: reset, then flush (a bubble wins over a hold), then stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            exmem_q <= '0;
        end else if (flushE) begin
            exmem_q <= '0;
        end else if (!stallE) begin
            exmem_q <= exmem_d;
        end
    end

    assign ALUOutM    = exmem_q.alu_out;
    assign WriteDataM = exmem_q.write_data;
    assign WA3M       = exmem_q.wa3;
    assign RegWriteM  = exmem_q.reg_write;
    assign MemWriteM  = exmem_q.mem_write;
    assign MemToRegM  = exmem_q.mem_to_reg;
    assign PCSrcM     = exmem_q.pc_src;
    assign PlusOneM   = exmem_q.plus_one;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//
// Self-checking bench for execute_stage: a directed vector table walking the
// reset / flag / condition / stall / flush scenarios, a randomized run against
// an arithmetic reference model, and a hand-written mid-operation reset.
// -----------------------------------------------------------------------------
module tb_execute_stage;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             stallE;
    logic             flushE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] WriteDataE;
    logic [WIDTH-1:0] WA3E;
    logic [1:0]       ALUControlE;
    logic [1:0]       FlagWriteE;
    logic [3:0]       CondE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             MemToRegE;
    logic             PCSrcE;
    logic             PlusOneE;
    logic [WIDTH-1:0] ALUOutM;
    logic [WIDTH-1:0] WriteDataM;
    logic [WIDTH-1:0] WA3M;
    logic             RegWriteM;
    logic             MemWriteM;
    logic             MemToRegM;
    logic             PCSrcM;
    logic             PlusOneM;
    logic [3:0]       FlagsOut;
    logic             CondExE;

    execute_stage #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .stallE     (stallE),
        .flushE     (flushE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .WriteDataE (WriteDataE),
        .WA3E       (WA3E),
        .ALUControlE(ALUControlE),
        .FlagWriteE (FlagWriteE),
        .CondE      (CondE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .MemToRegE  (MemToRegE),
        .PCSrcE     (PCSrcE),
        .PlusOneE   (PlusOneE),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .WA3M       (WA3M),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .MemToRegM  (MemToRegM),
        .PCSrcM     (PCSrcM),
        .PlusOneM   (PlusOneM),
        .FlagsOut   (FlagsOut),
        .CondExE    (CondExE)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one instruction on the falling edge, away from the active edge.
    task automatic apply(input logic rst, input logic stall, input logic flush,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [1:0] fw, input logic [3:0] cond,
                         input logic rw, input logic mw, input logic mtr,
                         input logic pcs, input logic po,
                         input logic [31:0] wd, input logic [31:0] wa3);
        @(negedge clock);
        reset       = rst;
        stallE      = stall;
        flushE      = flush;
        SrcAE       = a;
        SrcBE       = b;
        ALUControlE = op;
        FlagWriteE  = fw;
        CondE       = cond;
        RegWriteE   = rw;
        MemWriteE   = mw;
        MemToRegE   = mtr;
        PCSrcE      = pcs;
        PlusOneE    = po;
        WriteDataE  = wd;
        WA3E        = wa3;
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Result and flags from plain integer arithmetic: carry from a 64-bit
    // unsigned sum or an unsigned compare, overflow from the true signed
    // value falling outside the 32-bit range.
    task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           output logic [31:0] r, output logic [3:0] nzcv);
        longint unsigned ua, ub, us;
        longint          ss;
        int              sa, sb;
        logic            c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = a;
        sb = b;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            2'b00: begin
                us = ua + ub;
                r  = us[31:0];
                c  = us[32];
                ss = longint'(sa) + longint'(sb);
                v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'b01: begin
                r  = a - b;
                c  = (a >= b);
                ss = longint'(sa) - longint'(sb);
                v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        nzcv = {r[31], r == 32'd0, c, v};
    endtask

    logic [3:0]  m_flags;
    logic [31:0] m_alu, m_wd, m_wa3;
    logic        m_rw, m_mw, m_mtr, m_pcs, m_po;

    task automatic check_outputs(input string tag);
        check({tag, " ALUOutM"},    ALUOutM,    m_alu);
        check({tag, " WriteDataM"}, WriteDataM, m_wd);
        check({tag, " WA3M"},       WA3M,       m_wa3);
        check({tag, " ctrlM"},
              {27'd0, RegWriteM, MemWriteM, MemToRegM, PCSrcM, PlusOneM},
              {27'd0, m_rw, m_mw, m_mtr, m_pcs, m_po});
        check({tag, " FlagsOut"},   FlagsOut,   m_flags);
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: one row per cycle; CondExE is checked before the
    // edge, the M outputs and flags after it.
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst, stall, flush;
        logic [31:0] a, b;
        logic [1:0]  op, fw;
        logic [3:0]  cond;
        logic        rw, mw, pcs;
        logic        e_condex;
        logic [31:0] e_alu;
        logic        e_rw, e_mw, e_pcs;
        logic [3:0]  e_flags;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    initial begin
        reset = 1'b1; stallE = 1'b0; flushE = 1'b0;
        SrcAE = '0; SrcBE = '0; WriteDataE = '0; WA3E = '0;
        ALUControlE = '0; FlagWriteE = '0; CondE = 4'he;
        RegWriteE = 1'b0; MemWriteE = 1'b0; MemToRegE = 1'b0; PCSrcE = 1'b0; PlusOneE = 1'b0;

        //          rst stl fl  a             b             op     fw     cond   rw mw pcs  condex alu           rw mw pcs flags
        vecs[0]  = '{1, 0, 0, 32'h0000dead, 32'h00000001, 2'b00, 2'b11, 4'he, 1, 1, 1,   1, 32'h00000000, 0, 0, 0, 4'b0000};
        vecs[1]  = '{1, 0, 0, 32'h12345678, 32'h9abcdef0, 2'b01, 2'b11, 4'he, 1, 1, 1,   1, 32'h00000000, 0, 0, 0, 4'b0000};
        vecs[2]  = '{0, 0, 0, 32'h00000003, 32'h00000004, 2'b00, 2'b00, 4'he, 1, 0, 0,   1, 32'h00000007, 1, 0, 0, 4'b0000};
        vecs[3]  = '{0, 0, 0, 32'h7fffffff, 32'h00000001, 2'b00, 2'b11, 4'he, 0, 0, 0,   1, 32'h80000000, 0, 0, 0, 4'b1001};
        vecs[4]  = '{0, 0, 0, 32'h00000005, 32'h00000005, 2'b01, 2'b11, 4'he, 0, 0, 0,   1, 32'h00000000, 0, 0, 0, 4'b0110};
        vecs[5]  = '{0, 0, 0, 32'h00000001, 32'h00000002, 2'b00, 2'b00, 4'h1, 1, 1, 0,   0, 32'h00000003, 0, 0, 0, 4'b0110};
        vecs[6]  = '{0, 0, 0, 32'h00000010, 32'h00000002, 2'b00, 2'b00, 4'he, 1, 1, 0,   1, 32'h00000012, 1, 1, 0, 4'b0110};
        vecs[7]  = '{0, 1, 0, 32'h00000001, 32'h00000002, 2'b01, 2'b11, 4'he, 0, 0, 0,   1, 32'h00000012, 1, 1, 0, 4'b0110};
        vecs[8]  = '{0, 1, 0, 32'h00000001, 32'h00000002, 2'b01, 2'b11, 4'he, 0, 0, 0,   1, 32'h00000012, 1, 1, 0, 4'b0110};
        vecs[9]  = '{0, 1, 0, 32'h00000001, 32'h00000002, 2'b01, 2'b11, 4'he, 0, 0, 0,   1, 32'h00000012, 1, 1, 0, 4'b0110};
        vecs[10] = '{0, 0, 0, 32'h00000001, 32'h00000002, 2'b01, 2'b11, 4'he, 0, 0, 0,   1, 32'hffffffff, 0, 0, 0, 4'b1000};
        vecs[11] = '{0, 1, 1, 32'h000000f0, 32'h0000000f, 2'b10, 2'b10, 4'he, 1, 0, 0,   1, 32'h00000000, 0, 0, 0, 4'b1000};
        vecs[12] = '{0, 0, 0, 32'h00000000, 32'h00000000, 2'b00, 2'b11, 4'hf, 1, 0, 1,   0, 32'h00000000, 0, 0, 0, 4'b1000};
        vecs[13] = '{0, 0, 0, 32'h000000f0, 32'h0000000f, 2'b11, 2'b10, 4'hb, 1, 0, 1,   1, 32'h000000ff, 1, 0, 1, 4'b0000};

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].a, vecs[i].b,
                  vecs[i].op, vecs[i].fw, vecs[i].cond,
                  vecs[i].rw, vecs[i].mw, 1'b0, vecs[i].pcs, 1'b0,
                  32'h0, 32'h0);
            #1;
            check($sformatf("vec%0d CondExE", i), {31'd0, CondExE}, {31'd0, vecs[i].e_condex});
            @(posedge clock);
            #1;
            check($sformatf("vec%0d ALUOutM", i), ALUOutM, vecs[i].e_alu);
            check($sformatf("vec%0d RegWriteM/MemWriteM/PCSrcM", i),
                  {29'd0, RegWriteM, MemWriteM, PCSrcM},
                  {29'd0, vecs[i].e_rw, vecs[i].e_mw, vecs[i].e_pcs});
            check($sformatf("vec%0d FlagsOut", i), {28'd0, FlagsOut}, {28'd0, vecs[i].e_flags});
        end

        // --------------------------------------------------------------
        // Randomized run against the reference model. The first cycle is
        // a reset so model and DUT start from the same state.
        // --------------------------------------------------------------
        for (int i = 0; i < 600; i++) begin
            logic        rst, stall, flush, rw, mw, mtr, pcs, po, pass;
            logic [31:0] a, b, wd, wa3, r;
            logic [1:0]  op, fw;
            logic [3:0]  cond, nzcv;
            logic [31:0] specials [4];
            specials[0] = 32'h7fffffff;
            specials[1] = 32'h80000000;
            specials[2] = 32'h00000000;
            specials[3] = 32'hffffffff;

            rst   = (i == 0) || ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 7) == 0);
            a     = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            case ($urandom_range(0, 5))
                0:       b = a;
                1:       b = specials[$urandom_range(0, 3)];
                default: b = $urandom;
            endcase
            op    = 2'($urandom_range(0, 3));
            fw    = 2'($urandom_range(0, 3));
            cond  = ($urandom_range(0, 1) == 0) ? 4'he : 4'($urandom_range(0, 15));
            rw    = 1'($urandom_range(0, 1));
            mw    = 1'($urandom_range(0, 1));
            mtr   = 1'($urandom_range(0, 1));
            pcs   = 1'($urandom_range(0, 1));
            po    = 1'($urandom_range(0, 1));
            wd    = $urandom;
            wa3   = 32'($urandom_range(0, 15));

            apply(rst, stall, flush, a, b, op, fw, cond, rw, mw, mtr, pcs, po, wd, wa3);
            #1;
            pass = cond_ok(cond, m_flags);
            if (i != 0) check($sformatf("rnd%0d CondExE", i), {31'd0, CondExE}, {31'd0, pass});

            ref_alu(a, b, op, r, nzcv);
            if (rst) begin
                m_flags = 4'b0000;
                {m_alu, m_wd, m_wa3} = '0;
                {m_rw, m_mw, m_mtr, m_pcs, m_po} = '0;
            end else if (flush) begin
                {m_alu, m_wd, m_wa3} = '0;
                {m_rw, m_mw, m_mtr, m_pcs, m_po} = '0;
            end else if (!stall) begin
                m_alu = r;
                m_wd  = wd;
                m_wa3 = wa3;
                m_rw  = rw && pass;
                m_mw  = mw && pass;
                m_pcs = pcs && pass;
                m_mtr = mtr;
                m_po  = po;
                if (fw[1] && pass) m_flags[3:2] = nzcv[3:2];
                if (fw[0] && pass) m_flags[1:0] = nzcv[1:0];
            end

            @(posedge clock);
            #1;
            check_outputs($sformatf("rnd%0d", i));
        end

        // --------------------------------------------------------------
        // Reset in the middle of operation, asserted together with stall:
        // the in-flight instruction and the flags are both cleared.
        // --------------------------------------------------------------
        apply(1'b0, 1'b0, 1'b0, 32'hffffffff, 32'h00000002, 2'b00, 2'b11, 4'he,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hcafef00d, 32'd9);
        @(posedge clock);
        #1;
        check("midrst setup ALUOutM", ALUOutM, 32'h00000001);
        check("midrst setup FlagsOut", {28'd0, FlagsOut}, {28'd0, 4'b0010});
        check("midrst setup WA3M", WA3M, 32'd9);
        apply(1'b1, 1'b1, 1'b0, 32'h00000005, 32'h00000005, 2'b01, 2'b11, 4'he,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'd3);
        @(posedge clock);
        #1;
        check("midrst ALUOutM", ALUOutM, 32'h0);
        check("midrst WriteDataM", WriteDataM, 32'h0);
        check("midrst ctrlM",
              {27'd0, RegWriteM, MemWriteM, MemToRegM, PCSrcM, PlusOneM}, 32'h0);
        check("midrst FlagsOut", {28'd0, FlagsOut}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
